dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit that sits between the core's memory stage and the word-organised data memory (`dmem`), acting as the initiator on the memory's `addr`/`write_data`/`mem_write`/`dout` interface. It accepts byte-addressed byte/halfword/word requests over a valid/ready handshake. Sub-word stores are done as read-modify-write on the 32-bit memory word. Loads are returned sign- or zero-extended, and misaligned or out-of-range requests are rejected without touching memory.

## Interface
- `DATA_WIDTH`, 32: memory word width. Only 32 is supported.
- `MEM_DEPTH`, 1024: number of memory words. Must match the attached `dmem`.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request. Asserted in IDLE only.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `req_unsigned` input 1: loads only. 1 = zero-extend, 0 = sign-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned. Only the low byte or halfword is used for sub-word stores.
- `rsp_valid` output 1: one-cycle response pulse.
- `rsp_rdata` output 32: load result. 0 for stores and errors.
- `rsp_err` output 1: request rejected. Qualified by `rsp_valid`.
- `mem_addr` output $clog2(MEM_DEPTH): word index, driven to `dmem` addr.
- `mem_write_data` output 32: driven to `dmem` write_data.
- `mem_write` output 1: driven to `dmem` mem_write.
- `mem_dout` input 32: `dmem` asynchronous read data.

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid` at the clock edge, capture `req_we`, `req_size`, `req_unsigned`, `req_addr` and `req_wdata` into registers.
  - If the request is an error, go to RESP with the error flag set. Otherwise go to ACCESS.
- **Error conditions**
  - `req_size`=11.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `addr[31:2]` ≥ MEM_DEPTH.
- **ACCESS**
  - `mem_addr` = captured `addr[2+:$clog2(MEM_DEPTH)]`, `mem_write`=0.
  - Register `mem_dout` into `rdbuf` at the edge.
  - Load: go to RESP. Store: go to WRITE.
- **WRITE**
  - `mem_write`=1, `mem_addr` unchanged.
  - `mem_write_data` = `rdbuf` merged with the new data:
    - Byte store: `wdata[7:0]` replaces lane `addr[1:0]`.
    - Halfword store: `wdata[15:0]` replaces bits `[16*addr[1]+:16]`.
    - Word store: `wdata` replaces the whole word.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle, then go to IDLE.
  - Responses cannot be back-pressured; the consumer must take them.
- **Byte lanes and load extraction**
  - Little-endian: byte k occupies `[8k+7:8k]`.
  - Load byte extracts lane `addr[1:0]`; load halfword extracts `[16*addr[1]+:16]`.
  - Sign-extend from bit 7 or bit 15 unless `req_unsigned`=1.
  - Load word returns `rdbuf` unchanged.
- **Memory-side outputs outside ACCESS/WRITE**
  - `mem_write`=0.
  - `mem_addr` and `mem_write_data` hold their last value.
- **Simultaneous and mid-operation events**
  - `req_valid` in a non-IDLE state is ignored; `req_ready`=0.
  - Captured request fields are stable through the whole transaction, regardless of input changes.

## Timing
- **Reset values:**
  - State IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `mem_write`=0, `mem_addr`=0, `mem_write_data`=0.
- **Load:** accepted at edge E0. ACCESS runs in cycle E0–E1, RESP in cycle E1–E2. `rsp_valid` is high in the second cycle after acceptance (2-cycle latency). Next accept is possible at E2.
- **Store:** ACCESS, then WRITE, then RESP.
  - Memory is updated at the edge that ends WRITE (E2).
  - `rsp_valid` is high in cycle E2–E3 (3-cycle latency).
  - A load accepted at E3 observes the new data.
- **Error:** RESP in the cycle right after acceptance, with `rsp_err`=1. `mem_write` is never asserted.
- **Registered vs. combinational outputs:**
  - `mem_write` is a combinational decode of state.
  - `rsp_*` are registered and valid during RESP only. They return to 0 in IDLE.
- **Reset mid-operation:** `rst_n` low forces IDLE immediately and `mem_write` drops immediately. A store interrupted before the WRITE-ending edge leaves memory unmodified, and no response is produced.

## Test plan
- Reset, then word store 0xDEADBEEF @0x10, then word load @0x10 (signed):
  - `mem_write` is high exactly one cycle, word index 4.
  - Load `rsp_rdata`=0xDEADBEEF, 2 cycles after accept.
- Byte store 0xA5 @0x11 over word 0x11223344, then word load @0x10 → 0x1122A544. Byte load @0x11: signed → 0xFFFFFFA5, unsigned → 0x000000A5.
- Halfword store 0x8001 @0x12 over 0x00000000, then halfword load @0x12: signed → 0xFFFF8001, unsigned → 0x00008001.
- Errors: word load @0x13, halfword store @0x21, `size`=11, and load @(MEM_DEPTH*4) each give `rsp_err`=1 one cycle after accept. `mem_write` never rises and memory is unchanged.
- Back-to-back: `req_valid` held high across 4 requests gives `req_ready` low during each transaction. No request is lost or duplicated, and responses arrive in order.
- Assert `rst_n` low during the ACCESS cycle of a byte store. The prior word is unchanged, there is no `rsp_valid` pulse, and after release `req_ready`=1.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Bundle between the load/store unit, its requester and the word-organised data memory.
// The slave view is the LSU; the master view is the core request side plus the memory.
interface dmem_lsu_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
);
    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_write_data, mem_write,
        output mem_dout
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_write_data, mem_write,
        input  mem_dout
    );
endinterface

// File: rtl/dmem_lsu.sv
// Byte/halfword/word load-store unit in front of a 32-bit word memory with async read.
// Sub-word stores are read-modify-write; illegal requests are answered without a memory access.
module dmem_lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input logic       clk,
    input logic       rst_n,
    dmem_lsu_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef struct packed {
        logic                  we;
        logic [1:0]            size;
        logic                  zext;
        logic [1:0]            lane;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic [1:0]            state;
    logic [1:0]            next_state;
    req_t                  cap;
    logic                  req_err_c;
    logic                  accept_c;
    logic [7:0]            lane_byte_c;
    logic [15:0]           lane_half_c;
    logic [DATA_WIDTH-1:0] load_c;
    logic [DATA_WIDTH-1:0] merge_c;

    // Request legality: size, natural alignment and word-index range.
    always_comb begin
        req_err_c = 1'b0;
        case (bus.req_size)
            SZ_B:    req_err_c = 1'b0;
            SZ_H:    req_err_c = bus.req_addr[0];
            SZ_W:    req_err_c = (bus.req_addr[1:0] != 2'b00);
            default: req_err_c = 1'b1;
        endcase
        if (bus.req_addr[31:2] >= 30'(MEM_DEPTH)) begin
            req_err_c = 1'b1;
        end
    end

    assign accept_c = (state == IDLE) && bus.req_valid;

    // Next-state and state-decoded outputs.
    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        bus.mem_write = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    next_state = req_err_c ? RESP : ACCESS;
                end
            end
            ACCESS:  next_state = cap.we ? WRITE : RESP;
            WRITE: begin
                bus.mem_write = 1'b1;
                next_state    = RESP;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Load extraction from the addressed word, little-endian lanes.
    always_comb begin
        lane_byte_c = 8'h00;
        case (cap.lane)
            2'd0:    lane_byte_c = bus.mem_dout[7:0];
            2'd1:    lane_byte_c = bus.mem_dout[15:8];
            2'd2:    lane_byte_c = bus.mem_dout[23:16];
            default: lane_byte_c = bus.mem_dout[31:24];
        endcase
        lane_half_c = cap.lane[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
        load_c      = bus.mem_dout;
        case (cap.size)
            SZ_B:    load_c = {{(DATA_WIDTH-8){lane_byte_c[7] & ~cap.zext}}, lane_byte_c};
            SZ_H:    load_c = {{(DATA_WIDTH-16){lane_half_c[15] & ~cap.zext}}, lane_half_c};
            default: load_c = bus.mem_dout;
        endcase
    end

    // Store merge of the new data into the word read during ACCESS.
    always_comb begin
        merge_c = bus.mem_dout;
        case (cap.size)
            SZ_B: begin
                case (cap.lane)
                    2'd0:    merge_c[7:0]   = cap.wdata[7:0];
                    2'd1:    merge_c[15:8]  = cap.wdata[7:0];
                    2'd2:    merge_c[23:16] = cap.wdata[7:0];
                    default: merge_c[31:24] = cap.wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (cap.lane[1]) begin
                    merge_c[31:16] = cap.wdata[15:0];
                end else begin
                    merge_c[15:0] = cap.wdata[15:0];
                end
            end
            default: merge_c = cap.wdata;
        endcase
    end

    // Captured request, memory-side registers and the registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap                <= '0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_err        <= 1'b0;
            bus.rsp_rdata      <= '0;
        end else begin
            if (accept_c) begin
                cap.we    <= bus.req_we;
                cap.size  <= bus.req_size;
                cap.zext  <= bus.req_unsigned;
                cap.lane  <= bus.req_addr[1:0];
                cap.wdata <= bus.req_wdata;
                // Rejected requests leave the memory address untouched.
                if (!req_err_c) begin
                    bus.mem_addr <= bus.req_addr[2 +: ADDR_W];
                end
            end
            if ((state == ACCESS) && cap.we) begin
                bus.mem_write_data <= merge_c;
            end
            bus.rsp_valid <= (next_state == RESP);
            bus.rsp_err   <= accept_c && req_err_c;
            bus.rsp_rdata <= ((state == ACCESS) && !cap.we) ? load_c : '0;
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a vector table of single transactions against a behavioural
// dmem, then back-to-back issue and a reset landing inside a byte store.
module tb_dmem_lsu;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    logic [DW-1:0] mem [0:DEPTH-1];
    vec_t          vecs[$];
    vec_t          bb[4];

    dmem_lsu_if #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) bus ();

    dmem_lsu #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural dmem: asynchronous read, write on the rising edge.
    assign bus.mem_dout = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_write_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    function automatic void add(input bit we, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit err, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.err = err; v.rdata = rdata;
        vecs.push_back(v);
    endfunction

    function automatic int lat_of(input vec_t v);
        return v.err ? 1 : (v.we ? 3 : 2);
    endfunction

    task automatic drive(input vec_t v);
        bus.req_valid    = 1'b1;
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
    endtask

    // One transaction: latency, single response pulse, data, error flag and write count.
    task automatic do_req(input string tag, input vec_t v);
        int first_rsp;
        int rsp_cnt;
        int wr_cnt;
        logic [31:0] idx;
        idx = 32'(v.addr[11:2]);
        first_rsp = 0; rsp_cnt = 0; wr_cnt = 0;
        n_vec++;
        @(negedge clk);
        check({tag, " ready_idle"}, 32'(bus.req_ready), 32'd1);
        drive(v);
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the captured copy must be used.
        bus.req_valid    = 1'b0;
        bus.req_we       = ~v.we;
        bus.req_size     = ~v.size;
        bus.req_unsigned = ~v.uns;
        bus.req_addr     = ~v.addr;
        bus.req_wdata    = ~v.wdata;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, " ready_busy"}, 32'(bus.req_ready), 32'd0);
            if (bus.mem_write) begin
                wr_cnt++;
                check({tag, " write_idx"}, 32'(bus.mem_addr), idx);
            end
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (first_rsp == 0) begin
                    first_rsp = c;
                    check({tag, " rdata"}, bus.rsp_rdata, v.rdata);
                    check({tag, " err"}, 32'(bus.rsp_err), 32'(v.err));
                end
            end
        end
        check({tag, " latency"}, 32'(first_rsp), 32'(lat_of(v)));
        check({tag, " rsp_pulses"}, 32'(rsp_cnt), 32'd1);
        check({tag, " writes"}, 32'(wr_cnt), (v.we && !v.err) ? 32'd1 : 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, " rsp_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, " mem_write"}, 32'(bus.mem_write), 32'd0);
        check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, " mem_wdata"}, bus.mem_write_data, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   p, ri, busy;
        bit   adv;
        n_vec = 0;
        n_miss = 0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        rst_n = 1'b0;

        //   we size uns addr          wdata         err rdata
        add(1, W, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0000_0000);
        add(0, W, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF);
        add(1, W, 0, 32'h0000_0010, 32'h1122_3344, 0, 32'h0000_0000);
        add(1, B, 0, 32'h0000_0011, 32'h1234_56A5, 0, 32'h0000_0000);
        add(0, W, 0, 32'h0000_0010, 32'h0,         0, 32'h1122_A544);
        add(0, B, 0, 32'h0000_0011, 32'h0,         0, 32'hFFFF_FFA5);
        add(0, B, 1, 32'h0000_0011, 32'h0,         0, 32'h0000_00A5);
        add(1, W, 0, 32'h0000_0010, 32'h0000_0000, 0, 32'h0000_0000);
        add(1, H, 0, 32'h0000_0012, 32'hABCD_8001, 0, 32'h0000_0000);
        add(0, H, 0, 32'h0000_0012, 32'h0,         0, 32'hFFFF_8001);
        add(0, H, 1, 32'h0000_0012, 32'h0,         0, 32'h0000_8001);
        add(0, W, 0, 32'h0000_0010, 32'h0,         0, 32'h8001_0000);
        add(0, B, 0, 32'h0000_0013, 32'h0,         0, 32'hFFFF_FF80);
        add(0, H, 0, 32'h0000_0010, 32'h0,         0, 32'h0000_0000);
        add(1, B, 0, 32'h0000_0010, 32'hFFFF_FF5A, 0, 32'h0000_0000);
        add(1, B, 0, 32'h0000_0013, 32'h0000_007F, 0, 32'h0000_0000);
        add(0, W, 1, 32'h0000_0010, 32'h0,         0, 32'h7F01_005A);
        add(0, B, 0, 32'h0000_0013, 32'h0,         0, 32'h0000_007F);
        add(0, W, 0, 32'h0000_0013, 32'h0,         1, 32'h0000_0000);
        add(1, H, 0, 32'h0000_0021, 32'hFFFF_FFFF, 1, 32'h0000_0000);
        add(0, X, 0, 32'h0000_0010, 32'h0,         1, 32'h0000_0000);
        add(0, W, 0, 32'h0000_1000, 32'h0,         1, 32'h0000_0000);
        add(0, W, 0, 32'h8000_0010, 32'h0,         1, 32'h0000_0000);
        add(1, W, 0, 32'h0000_0016, 32'hFFFF_FFFF, 1, 32'h0000_0000);
        add(1, B, 0, 32'h0000_1000, 32'h0000_00FF, 1, 32'h0000_0000);
        add(0, W, 0, 32'h0000_0020, 32'h0,         0, 32'h0000_0000);
        add(0, W, 0, 32'h0000_0010, 32'h0,         0, 32'h7F01_005A);
        add(1, W, 0, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 32'h0000_0000);
        add(0, W, 0, 32'h0000_0FFC, 32'h0,         0, 32'hCAFE_F00D);
        add(0, H, 1, 32'h0000_0FFE, 32'h0,         0, 32'h0000_CAFE);
        add(0, H, 0, 32'h0000_0FFE, 32'h0,         0, 32'hFFFF_CAFE);
        add(0, B, 0, 32'h0000_0FFF, 32'h0,         0, 32'hFFFF_FFCA);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) do_req($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back: req_valid stays high, next request presented right after each accept.
        bb[0].we = 1; bb[0].size = W; bb[0].uns = 0; bb[0].addr = 32'h40; bb[0].wdata = 32'h0102_0304; bb[0].err = 0; bb[0].rdata = 32'h0;
        bb[1].we = 0; bb[1].size = W; bb[1].uns = 0; bb[1].addr = 32'h40; bb[1].wdata = 32'h0;         bb[1].err = 0; bb[1].rdata = 32'h0102_0304;
        bb[2].we = 1; bb[2].size = B; bb[2].uns = 0; bb[2].addr = 32'h43; bb[2].wdata = 32'h0000_00EE; bb[2].err = 0; bb[2].rdata = 32'h0;
        bb[3].we = 0; bb[3].size = W; bb[3].uns = 1; bb[3].addr = 32'h40; bb[3].wdata = 32'h0;         bb[3].err = 0; bb[3].rdata = 32'hEE02_0304;
        @(negedge clk);
        drive(bb[0]);
        p = 0; ri = 0; busy = 0; adv = 0;
        for (int c = 0; c < 60 && (ri < 4 || busy > 0); c++) begin
            if (adv) begin
                p++;
                if (p < 4) drive(bb[p]);
                else bus.req_valid = 1'b0;
                adv = 0;
            end
            check($sformatf("b2b ready c%0d", c), 32'(bus.req_ready), (busy == 0) ? 32'd1 : 32'd0);
            if (bus.rsp_valid) begin
                if (ri < 4) begin
                    check($sformatf("b2b rdata r%0d", ri), bus.rsp_rdata, bb[ri].rdata);
                    check($sformatf("b2b err r%0d", ri), 32'(bus.rsp_err), 32'(bb[ri].err));
                end else begin
                    check("b2b extra_rsp", 32'(ri), 32'd3);
                end
                ri++;
            end
            if (busy > 0) busy--;
            else if (p < 4) begin
                busy = lat_of(bb[p]);
                adv = 1;
                n_vec++;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("b2b rsp_count", 32'(ri), 32'd4);
        for (int c = 0; c < 4; c++) begin
            check("b2b quiet", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end

        // Reset landing in the ACCESS cycle of a byte store.
        v.we = 1; v.size = W; v.uns = 0; v.addr = 32'h50; v.wdata = 32'h5566_7788; v.err = 0; v.rdata = 32'h0;
        do_req("rst_pre", v);
        v.we = 1; v.size = B; v.addr = 32'h51; v.wdata = 32'h0000_00AA;
        @(negedge clk);
        drive(v);
        n_vec++;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst access ready", 32'(bus.req_ready), 32'd0);
        check("rst access write", 32'(bus.mem_write), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst mid ready", 32'(bus.req_ready), 32'd1);
        check("rst mid write", 32'(bus.mem_write), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst hold rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst hold write", 32'(bus.mem_write), 32'd0);
        end
        check_idle_outputs("rst_mid");
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst post rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst post ready", 32'(bus.req_ready), 32'd1);
        end
        v.we = 0; v.size = W; v.uns = 0; v.addr = 32'h50; v.wdata = 32'h0; v.err = 0; v.rdata = 32'h5566_7788;
        do_req("rst_word", v);
        v.size = B; v.uns = 1; v.addr = 32'h51; v.rdata = 32'h0000_0077;
        do_req("rst_byte", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
